// File: rtl/wb_timer_if.sv
// Wishbone pipelined-mode bus bundle shared by the CPU, the MMU and the peripherals.
`timescale 1ns/1ps

interface if_wb;
    logic [31:0] adr;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_m;
    logic [31:0] dat_s;
    logic        ack;
    logic        stall;

    modport master (
        output adr, cyc, stb, we, sel, dat_m,
        input  dat_s, ack, stall
    );

    modport slave (
        input  adr, cyc, stb, we, sel, dat_m,
        output dat_s, ack, stall
    );
endinterface

// File: rtl/wb_timer.sv
// Interval timer on a Wishbone pipelined slave port: a 32-bit down-counter with
// a reload register, a sticky expiry flag and a registered level interrupt.
`timescale 1ns/1ps

module wb_timer #(
    parameter int unsigned DIV           = 1,
    parameter logic [31:0] RESET_COMPARE = 32'hffff_ffff
) (
    input  logic clk_i,
    input  logic rst_i,
    if_wb.slave  bus,
    output logic irq
);

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_STATUS  = 2'd1,
        REG_COMPARE = 2'd2,
        REG_COUNT   = 2'd3
    } reg_e;

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    // Overwrite only the byte lanes selected by the master.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic        ie_q, ie_d;
    logic        exp_q, exp_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] count_q, count_d;
    logic [15:0] pre_q, pre_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        irq_q, irq_d;

    logic        accept;
    logic        tick;
    reg_e        reg_sel;
    logic [31:0] rd_data;
    logic        unused_adr;

    // The MMU has already decoded the upper address bits; byte offset is implied by sel.
    assign unused_adr = ^{bus.adr[31:4], bus.adr[1:0]};

    assign accept  = bus.cyc & bus.stb;
    assign reg_sel = reg_e'(bus.adr[3:2]);
    assign tick    = en_q && (pre_q == DIV_LAST);

    // Read mux: register contents as they stand before this edge's updates.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        rd_data = '0;
        unique case (reg_sel)
            REG_CTRL:    rd_data = {29'd0, ie_q, auto_q, en_q};
            REG_STATUS:  rd_data = {31'd0, exp_q};
            REG_COMPARE: rd_data = compare_q;
            REG_COUNT:   rd_data = count_q;
            default:     rd_data = '0;
        endcase
    end

    // Next-state: prescaler, counter/expiry, then bus writes layered on top so the bus wins.
    always_comb begin
        en_d      = en_q;
        auto_d    = auto_q;
        ie_d      = ie_q;
        exp_d     = exp_q;
        compare_d = compare_q;
        count_d   = count_q;
        pre_d     = '0;
        ack_d     = accept;
        dat_d     = '0;
        irq_d     = exp_q & ie_q;

        if (en_q) begin
            pre_d = tick ? 16'd0 : pre_q + 16'd1;
        end

        if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else begin
                exp_d = 1'b1;
                if (auto_q) count_d = compare_q;
                else        en_d    = 1'b0;
            end
        end

        if (accept && !bus.we) begin
            dat_d = rd_data;
        end

        if (accept && bus.we) begin
            unique case (reg_sel)
                REG_CTRL: begin
                    if (bus.sel[0]) begin
                        en_d   = bus.dat_m[0];
                        auto_d = bus.dat_m[1];
                        ie_d   = bus.dat_m[2];
                    end
                end
                REG_STATUS: begin
                    // A new expiry on the same edge keeps the flag set.
                    if (bus.sel[0] && bus.dat_m[0] && !(tick && count_q == 32'd0)) begin
                        exp_d = 1'b0;
                    end
                end
                REG_COMPARE: compare_d = merge_bytes(compare_q, bus.dat_m, bus.sel);
                REG_COUNT:   count_d   = merge_bytes(count_q, bus.dat_m, bus.sel);
                default: ;
            endcase
        end
    end

    // State register with asynchronous reset; a pending ack is dropped by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            ie_q      <= 1'b0;
            exp_q     <= 1'b0;
            compare_q <= RESET_COMPARE;
            count_q   <= '0;
            pre_q     <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            en_q      <= en_d;
            auto_q    <= auto_d;
            ie_q      <= ie_d;
            exp_q     <= exp_d;
            compare_q <= compare_d;
            count_q   <= count_d;
            pre_q     <= pre_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            irq_q     <= irq_d;
        end
    end

    // The master aborts an outstanding request by dropping cyc in the ack cycle.
    assign bus.ack   = ack_q & bus.cyc;
    assign bus.dat_s = dat_q;
    assign bus.stall = 1'b0;
    assign irq       = irq_q;

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer: one DIV=1 instance and one DIV=4 instance on a shared master.
`timescale 1ns/1ps

module tb_wb_timer;

    localparam logic [1:0] A_CTRL    = 2'd0;
    localparam logic [1:0] A_STATUS  = 2'd1;
    localparam logic [1:0] A_COMPARE = 2'd2;
    localparam logic [1:0] A_COUNT   = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dsel = 1'b0;
    logic [31:0] adr = '0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] dat_m = '0;

    logic        irq1, irq4;
    logic        ack, stall, irq;
    logic [31:0] dat_s;

    int total = 0;
    int fails = 0;

    if_wb bus1 ();
    if_wb bus4 ();

    assign bus1.adr = adr;   assign bus4.adr = adr;
    assign bus1.stb = stb;   assign bus4.stb = stb;
    assign bus1.we  = we;    assign bus4.we  = we;
    assign bus1.sel = sel;   assign bus4.sel = sel;
    assign bus1.dat_m = dat_m;
    assign bus4.dat_m = dat_m;
    assign bus1.cyc = cyc & ~dsel;
    assign bus4.cyc = cyc & dsel;

    assign ack   = dsel ? bus4.ack   : bus1.ack;
    assign stall = dsel ? bus4.stall : bus1.stall;
    assign dat_s = dsel ? bus4.dat_s : bus1.dat_s;
    assign irq   = dsel ? irq4       : irq1;

    wb_timer #(.DIV(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1), .irq(irq1));
    wb_timer #(.DIV(4)) u_dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4), .irq(irq4));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Single write; called at a negedge, returns at the negedge after the accept edge.
    task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s, input string tag);
        adr = {26'h0001234, r, 2'b00}; cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = s; dat_m = d;
        @(negedge clk);
        check({tag, "_ack"}, {31'd0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; dat_m = '0;
    endtask

    // Single read; called at a negedge, returns at the negedge after the accept edge.
    task automatic rd(input logic [1:0] r, input logic [31:0] expv, input string tag);
        adr = {28'd0, r, 2'b00}; cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hf;
        @(negedge clk);
        check({tag, "_ack"}, {31'd0, ack}, 32'd1);
        check(tag, dat_s, expv);
        cyc = 1'b0; stb = 1'b0; sel = '0;
    endtask

    logic [31:0] reset_vals [4];

    initial begin
        reset_vals[0] = 32'd0;
        reset_vals[1] = 32'd0;
        reset_vals[2] = 32'hffff_ffff;
        reset_vals[3] = 32'd0;

        // Reset state on both instances.
        idle(2);
        check("rst_ack1",   {31'd0, bus1.ack},   32'd0);
        check("rst_stall1", {31'd0, bus1.stall}, 32'd0);
        check("rst_dat1",   bus1.dat_s,          32'd0);
        check("rst_irq1",   {31'd0, irq1},       32'd0);
        check("rst_ack4",   {31'd0, bus4.ack},   32'd0);
        check("rst_irq4",   {31'd0, irq4},       32'd0);
        rst = 1'b0;
        idle(1);

        // Four pipelined reads on consecutive cycles, acks in order one cycle behind.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hf;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                check($sformatf("b2b_ack%0d", i - 1), {31'd0, ack}, 32'd1);
                check($sformatf("b2b_dat%0d", i - 1), dat_s, reset_vals[i - 1]);
            end
            check($sformatf("b2b_stall%0d", i), {31'd0, stall}, 32'd0);
            if (i < 4) begin
                adr = 32'(i) << 2;
                @(negedge clk);
            end
        end
        cyc = 1'b0; stb = 1'b0;
        idle(1);
        check("b2b_ack_end", {31'd0, ack}, 32'd0);

        // DIV=1 auto-reload: COMPARE=3, COUNT=3, enable at edge P0.
        wr(A_COMPARE, 32'd3, 4'hf, "d1_cmp");
        wr(A_COUNT,   32'd3, 4'hf, "d1_cnt");
        wr(A_CTRL,    32'd7, 4'hf, "d1_ctrl");     // now at N0
        idle(3);                                   // N3
        rd(A_STATUS, 32'd0, "d1_exp_before");      // sampled before P4
        check("d1_irq_n4", {31'd0, irq}, 32'd0);
        rd(A_COUNT, 32'd3, "d1_reload");           // reloaded at P4
        check("d1_irq_n5", {31'd0, irq}, 32'd1);
        rd(A_STATUS, 32'd1, "d1_exp_set");         // N6
        wr(A_STATUS, 32'd1, 4'h1, "d1_w1c");       // clears at P7, now N7
        check("d1_irq_n7", {31'd0, irq}, 32'd1);
        idle(1);
        check("d1_irq_fall", {31'd0, irq}, 32'd0);
        idle(1);
        check("d1_irq_period", {31'd0, irq}, 32'd1); // re-expiry at P8
        idle(2);                                   // N11
        wr(A_STATUS, 32'd1, 4'h1, "d1_w1c_exp");   // lands on expiry edge P12
        rd(A_STATUS, 32'd1, "d1_set_wins");
        wr(A_STATUS, 32'd1, 4'h1, "d1_w1c2");      // P14, no expiry
        rd(A_STATUS, 32'd0, "d1_cleared");
        wr(A_CTRL, 32'd0, 4'hf, "d1_stop");
        wr(A_STATUS, 32'd1, 4'h1, "d1_clr");

        // One-shot: AUTO=0, IE=0.
        wr(A_COMPARE, 32'd2, 4'hf, "os_cmp");
        wr(A_COUNT,   32'd2, 4'hf, "os_cnt");
        wr(A_CTRL,    32'd1, 4'hf, "os_ctrl");     // M0
        idle(2);
        rd(A_STATUS, 32'd0, "os_exp_before");      // sampled before third tick
        rd(A_STATUS, 32'd1, "os_exp_set");
        rd(A_CTRL,   32'd0, "os_en_cleared");
        rd(A_COUNT,  32'd0, "os_count_hold");
        check("os_irq_masked", {31'd0, irq}, 32'd0);
        wr(A_STATUS, 32'd1, 4'h1, "os_clr");
        idle(20);
        rd(A_STATUS, 32'd0, "os_no_reexp");
        rd(A_COUNT,  32'd0, "os_count_still0");

        // Byte-lane write and cycle abort.
        wr(A_COUNT, 32'h1122_3344, 4'hf, "sel_full");
        wr(A_COUNT, 32'h0000_ab00, 4'b0010, "sel_lane1");
        rd(A_COUNT, 32'h1122_ab44, "sel_merge");
        adr = {28'd0, A_COUNT, 2'b00}; cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hf;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        #1;
        check("abort_ack", {31'd0, ack}, 32'd0);
        @(negedge clk);
        check("abort_ack_next", {31'd0, ack}, 32'd0);

        // DIV=4 instance: COMPARE=1, AUTO=1 -> 8-clock period.
        dsel = 1'b1;
        wr(A_COMPARE, 32'd1, 4'hf, "d4_cmp");
        wr(A_COUNT,   32'd1, 4'hf, "d4_cnt");
        wr(A_CTRL,    32'd7, 4'hf, "d4_ctrl");     // M0
        idle(8);
        check("d4_irq_m8", {31'd0, irq}, 32'd0);
        idle(1);
        check("d4_irq_m9", {31'd0, irq}, 32'd1);   // expiry at Q8
        wr(A_STATUS, 32'd1, 4'h1, "d4_w1c");       // M10
        idle(1);
        check("d4_irq_m11", {31'd0, irq}, 32'd0);
        idle(5);
        check("d4_irq_m16", {31'd0, irq}, 32'd0);
        idle(1);
        check("d4_irq_m17", {31'd0, irq}, 32'd1);  // next expiry at Q16

        // Asynchronous reset with an ack pending.
        adr = {28'd0, A_COUNT, 2'b00}; cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hf;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_ack",   {31'd0, ack},   32'd0);
        check("arst_irq",   {31'd0, irq},   32'd0);
        check("arst_dat",   dat_s,          32'd0);
        check("arst_stall", {31'd0, stall}, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        rd(A_COUNT,   32'd0,         "arst_count");
        rd(A_CTRL,    32'd0,         "arst_ctrl");
        rd(A_COMPARE, 32'hffff_ffff, "arst_compare");
        rd(A_STATUS,  32'd0,         "arst_status");

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
